vend_fsm_param: RTL and testbench

//  Parametrised vending controller. Coin inputs of three values (0.5/1/2 units) accumulate credit.

---
 rtl/vend_pkg.sv | 31 +++
 rtl/vend_payout_ctr.sv | 43 ++++
 rtl/vend_fsm_param.sv | 116 +++++++++++
 tb/tb_vend_fsm_param.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and coin constants for the vending controller.
// Coin decode lives here so the FSM and any future front-end agree on values.
package vend_pkg;

  typedef enum logic [2:0] {
    ST_ACCUM  = 3'b001,
    ST_PAYOUT = 3'b010
  } state_e;

  localparam int COIN_HALF = 1;
  localparam int COIN_ONE  = 2;
  localparam int COIN_TWO  = 4;

  // Zero unless exactly one coin line is high
  function automatic logic [2:0] coin_val(
    input logic half,
    input logic one,
    input logic two
  );
    logic [2:0] v;
    v = '0;
    case ({two, one, half})
      3'b001:  v = 3'(COIN_HALF);
      3'b010:  v = 3'(COIN_ONE);
      3'b100:  v = 3'(COIN_TWO);
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/vend_payout_ctr.sv
// Change pay-out counter: one money pulse every other cycle
// until the loaded change is exhausted.
module vend_payout_ctr #(
  parameter int W = 4
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  input  logic         load,
  input  logic [W-1:0] change,
  output logic         money,
  output logic         done
);

  logic [W-1:0] cnt;
  logic         ph;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt   <= '0;
      ph    <= 1'b0;
      money <= 1'b0;
    end else if (load) begin
      cnt   <= change;
      ph    <= 1'b0;
      money <= 1'b0;
    end else if (cnt != '0) begin
      if (!ph) begin
        money <= 1'b1;
        cnt   <= cnt - 1'b1;
        ph    <= 1'b1;
      end else begin
        money <= 1'b0;
        ph    <= 1'b0;
      end
    end else begin
      money <= 1'b0;
      ph    <= 1'b0;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/vend_fsm_param.sv
// Parametrised vending controller: accumulates coin credit,
// vends at PRICE, pays change or refunds as serial pulses.
module vend_fsm_param
  import vend_pkg::*;
#(
  parameter int PRICE    = 10,
  parameter int CREDIT_W = 4
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                pi_money_half,
  input  logic                pi_money_one,
  input  logic                pi_money_two,
  input  logic                pi_cancel,
  output logic                po_cola,
  output logic                po_money,
  output logic [CREDIT_W-1:0] po_credit,
  output logic                po_busy
);

  if (PRICE < 1 || PRICE + 4 > 2 ** CREDIT_W) begin : g_bad_param
    $error("vend_fsm_param: PRICE does not fit CREDIT_W");
  end

  localparam logic [CREDIT_W:0] PRICE_W = (CREDIT_W + 1)'(PRICE);

  state_e              state;
  logic [CREDIT_W-1:0] credit;
  logic [2:0]          val;
  logic [CREDIT_W:0]   nxt;
  logic                refund;
  logic                vend;
  logic                pay_load;
  logic [CREDIT_W-1:0] pay_chg;
  logic                pay_done;

  assign val = coin_val(pi_money_half, pi_money_one, pi_money_two);
  assign nxt = {1'b0, credit} + (CREDIT_W + 1)'(val);

  // Cancel wins over a same-cycle vend: the coin is refunded too
  always_comb begin
    refund   = 1'b0;
    vend     = 1'b0;
    pay_load = 1'b0;
    pay_chg  = '0;
    case (state)
      ST_ACCUM: begin
        if (pi_cancel && nxt != '0) begin
          refund   = 1'b1;
          pay_load = 1'b1;
          pay_chg  = nxt[CREDIT_W-1:0];
        end else if (val != '0 && nxt >= PRICE_W) begin
          vend     = 1'b1;
          pay_load = 1'b1;
          pay_chg  = CREDIT_W'(nxt - PRICE_W);
        end
      end
      ST_PAYOUT: ;
      default: pay_load = 1'b1;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= ST_ACCUM;
      credit  <= '0;
      po_cola <= 1'b0;
      po_busy <= 1'b0;
    end else begin
      po_cola <= 1'b0;
      case (state)
        ST_ACCUM: begin
          if (refund) begin
            credit  <= '0;
            state   <= ST_PAYOUT;
            po_busy <= 1'b1;
          end else if (vend) begin
            credit  <= '0;
            po_cola <= 1'b1;
            if (pay_chg != '0) begin
              state   <= ST_PAYOUT;
              po_busy <= 1'b1;
            end
          end else if (val != '0) begin
            credit <= nxt[CREDIT_W-1:0];
          end
        end
        ST_PAYOUT: begin
          if (pay_done) begin
            state   <= ST_ACCUM;
            po_busy <= 1'b0;
          end
        end
        default: begin
          state   <= ST_ACCUM;
          credit  <= '0;
          po_busy <= 1'b0;
        end
      endcase
    end
  end

  vend_payout_ctr #(
    .W(CREDIT_W)
  ) u_payout (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .load      (pay_load),
    .change    (pay_chg),
    .money     (po_money),
    .done      (pay_done)
  );

  assign po_credit = credit;

endmodule

// File: tb/tb_vend_fsm_param.sv
// Scoreboard bench for vend_fsm_param: event-time reference model
// feeds queues; a negedge monitor pops and compares.
module tb_vend_fsm_param;

  localparam int P = 5;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       h = 0, o = 0, t = 0, c = 0;
  logic       cola, money, busy;
  logic [3:0] credit;
  logic       b_h = 0, b_o = 0, b_t = 0, b_c = 0;
  logic       b_cola, b_money, b_busy;
  logic [3:0] b_credit;

  always #5 sys_clk = ~sys_clk;

  vend_fsm_param #(.PRICE(P), .CREDIT_W(4)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .pi_money_half(h), .pi_money_one(o),
    .pi_money_two(t), .pi_cancel(c),
    .po_cola(cola), .po_money(money),
    .po_credit(credit), .po_busy(busy)
  );

  vend_fsm_param #(.PRICE(4), .CREDIT_W(4)) dut4 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .pi_money_half(b_h), .pi_money_one(b_o),
    .pi_money_two(b_t), .pi_cancel(b_c),
    .po_cola(b_cola), .po_money(b_money),
    .po_credit(b_credit), .po_busy(b_busy)
  );

  typedef struct packed {
    int   cyc;
    logic is_cola;
  } ev_t;

  typedef struct packed {
    int   cyc;
    int   credit;
    logic busy;
  } st_t;

  ev_t evq[$];
  st_t stq[$];
  ev_t em;
  st_t sm;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 0;
  int m_credit = 0;
  int m_busy_until = -1;
  int b_busy_cnt = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0d expected %0d",
               name, cyc, act, exp);
    end
  endtask

  // Reference model: inputs in cycle n decide outputs from n+1 on
  task automatic step(input bit hh, input bit oo,
                      input bit tt, input bit cc);
    int  n, v, nxt, chg;
    bit  valid;
    ev_t e;
    st_t s;
    @(posedge sys_clk);
    #1;
    h = hh; o = oo; t = tt; c = cc;
    n = cyc;
    if (n > m_busy_until) begin
      valid = (int'(hh) + int'(oo) + int'(tt)) == 1;
      v = !valid ? 0 : hh ? 1 : oo ? 2 : 4;
      nxt = m_credit + v;
      chg = 0;
      if (cc && nxt > 0) begin
        chg = nxt;
        m_credit = 0;
      end else if (valid && nxt >= P) begin
        e.cyc = n + 1;
        e.is_cola = 1'b1;
        evq.push_back(e);
        chg = nxt - P;
        m_credit = 0;
      end else if (valid) begin
        m_credit = nxt;
      end
      for (int k = 1; k <= chg; k++) begin
        e.cyc = n + 2 * k;
        e.is_cola = 1'b0;
        evq.push_back(e);
      end
      if (chg > 0) m_busy_until = n + 2 * chg;
    end
    s.cyc = n + 1;
    s.credit = m_credit;
    s.busy = (n + 1 <= m_busy_until);
    stq.push_back(s);
  endtask

  always @(negedge sys_clk) begin
    if (b_busy) b_busy_cnt++;
    if (mon_en) begin
      while (evq.size() > 0 && evq[0].cyc < cyc) begin
        em = evq.pop_front();
        chk("missed_pulse", cyc, em.cyc);
      end
      if (cola || money) begin
        if (evq.size() == 0) begin
          chk("unexpected_pulse", {cola, money}, 0);
        end else begin
          em = evq.pop_front();
          chk("pulse_cycle", cyc, em.cyc);
          chk("pulse_kind_cola", cola, em.is_cola);
          chk("pulse_kind_money", money, !em.is_cola);
        end
      end
      if (stq.size() > 0 && stq[0].cyc == cyc) begin
        sm = stq.pop_front();
        chk("credit", credit, sm.credit);
        chk("busy", busy, sm.busy);
      end
    end
  end

  task automatic mid_reset();
    @(posedge sys_clk);
    #3;
    mon_en = 0;
    h = 0; o = 0; t = 0; c = 0;
    sys_rst_n = 1'b0;
    #1;
    chk("rst_cola", cola, 0);
    chk("rst_money", money, 0);
    chk("rst_busy", busy, 0);
    chk("rst_credit", credit, 0);
    evq.delete();
    stq.delete();
    m_credit = 0;
    m_busy_until = -1;
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    mon_en = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    int a;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("reset_cola", cola, 0);
    chk("reset_money", money, 0);
    chk("reset_credit", credit, 0);
    chk("reset_busy", busy, 0);
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    mon_en = 1;

    step(1, 0, 0, 0); step(0, 1, 0, 0); step(0, 1, 0, 0);
    repeat (3) step(0, 0, 0, 0);

    step(0, 1, 0, 0); step(0, 1, 0, 0); step(0, 0, 1, 0);
    repeat (9) step(0, 0, 0, 0);

    step(0, 1, 0, 0); step(1, 0, 0, 0); step(0, 0, 0, 1);
    repeat (8) step(0, 0, 0, 0);

    step(1, 1, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 1);
    step(0, 1, 0, 0); step(0, 1, 0, 0); step(0, 0, 1, 0);
    step(1, 0, 0, 0); step(0, 0, 1, 0); step(0, 0, 0, 1);
    repeat (8) step(0, 0, 0, 0);

    step(0, 1, 0, 0); step(0, 1, 0, 0); step(0, 0, 1, 0);
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    mid_reset();
    repeat (3) step(0, 0, 0, 0);

    repeat (3000) begin
      r = $urandom_range(0, 11);
      case (r)
        0: step(1, 0, 0, 0);
        1: step(0, 1, 0, 0);
        2: step(0, 0, 1, 0);
        3: step(1, 0, 1, 0);
        4: step(bit'($urandom), bit'($urandom), bit'($urandom), 1);
        5: step(0, 1, 1, 0);
        default: step(0, 0, 0, 0);
      endcase
    end
    repeat (20) step(0, 0, 0, 0);
    chk("drain_events", evq.size(), 0);

    @(posedge sys_clk);
    #1;
    b_t = 1;
    a = cyc;
    @(posedge sys_clk);
    #1;
    @(negedge sys_clk);
    chk("p4_cycle", cyc, a + 1);
    chk("p4_cola1", b_cola, 1);
    chk("p4_credit1", b_credit, 0);
    @(posedge sys_clk);
    #1;
    b_t = 0;
    @(negedge sys_clk);
    chk("p4_cola2", b_cola, 1);
    @(posedge sys_clk);
    @(negedge sys_clk);
    chk("p4_cola3", b_cola, 0);
    chk("p4_money", b_money, 0);
    chk("p4_busy_cnt", b_busy_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
